// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stages.
//   powerInstrWidth : Power ISA instruction width (always 32 bits)
//   fetchState_e    : state encoding of the cacheline fetch parser
//   wordsPerLine()  : number of 32-bit words in a line of 2**offsetBits bytes
//   wordIdxBits()   : bits needed to address one word inside such a line
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int powerInstrWidth = 32;

  typedef enum logic {
    IDLE,
    EMIT
  } fetchState_e;

  function automatic int wordsPerLine(input int offsetBits);
    return (2 ** offsetBits) / 4;
  endfunction

  function automatic int wordIdxBits(input int offsetBits);
    return $clog2(wordsPerLine(offsetBits));
  endfunction

endpackage

// File: rtl/fetch_group_select.sv
// ---------------------------------------------------------------------------
// fetch_group_select
// Combinational selection of one fetch group out of a buffered cacheline.
// Slot k carries the word at index wIdx_i+k. A slot whose word index runs
// past the end of the line is marked invalid and its payload is zero.
// Ports:
//   line_i      : cacheline, word j at bits [j*instrWidth +: instrWidth]
//   wIdx_i      : word index of slot 0 (one bit wider than a word index)
//   payload_o   : fetchWidth instructions, slot k at [k*instrWidth +: instrWidth]
//   slotValid_o : per-slot valid mask, bit k belongs to slot k
// ---------------------------------------------------------------------------
module fetch_group_select
  import fetch_pkg::*;
#(
  parameter int cachelineSizeInBits = 256,
  parameter int instrWidth          = powerInstrWidth,
  parameter int fetchWidth          = 2,
  parameter int wIdxWidth           = 4
) (
  input  logic [0:cachelineSizeInBits-1]   line_i,
  input  logic [wIdxWidth-1:0]             wIdx_i,
  output logic [0:fetchWidth*instrWidth-1] payload_o,
  output logic [0:fetchWidth-1]            slotValid_o
);

  localparam int wordsPerLineC = cachelineSizeInBits / instrWidth;

  for (genvar k = 0; k < fetchWidth; k++) begin : gSlot
    logic [wIdxWidth-1:0]  wordSel;
    logic [instrWidth-1:0] slotWord;

    // wIdxWidth has one spare bit, so wIdx_i+k never wraps back into the line.
    assign wordSel = wIdx_i + wIdxWidth'(k);

    always_comb begin
      slotWord = '0;
      for (int j = 0; j < wordsPerLineC; j++) begin
        if (wordSel == wIdxWidth'(j)) begin
          slotWord = line_i[j*instrWidth +: instrWidth];
        end
      end
    end

    assign payload_o[k*instrWidth +: instrWidth] = slotWord;
    assign slotValid_o[k] = (wordSel < wIdxWidth'(wordsPerLineC));
  end

endmodule

// File: rtl/cacheline_fetch_parser.sv
// ---------------------------------------------------------------------------
// cacheline_fetch_parser
// Accepts one fetched cacheline plus its tag/index/offset and streams it to
// the decoders as fetch groups of up to fetchWidth instructions per beat,
// starting at the (word-aligned) fetch offset and running to the line end.
// Ports:
//   clock_i, resetn_i       : clock, asynchronous active-low reset
//   flushPipeline_i         : synchronous flush, aborts the line in flight
//   enable_i / ready_o      : input line handshake
//   cacheline_i             : line data, word j at [j*32 +: 32]
//   tag_i, index_i, offset_i: fetch address fields of the line
//   enable_o / ready_i      : output beat handshake
//   fetchedPayload_o        : slot k at [k*32 +: 32]
//   slotValid_o             : per-slot valid, bit 0 = slot 0
//   tag_o, index_o          : address of the line being streamed
//   offset_o                : byte offset of slot 0
//   lastBeat_o              : beat holds the last word of the line
// ---------------------------------------------------------------------------
module cacheline_fetch_parser
  import fetch_pkg::*;
#(
  parameter int offsetSize          = 5,
  parameter int indexSize           = 8,
  parameter int tagSize             = 64 - (offsetSize + indexSize),
  parameter int cachelineSizeInBits = (2 ** offsetSize) * 8,
  parameter int instrWidth          = powerInstrWidth,
  parameter int fetchWidth          = 2
) (
  input  logic                             clock_i,
  input  logic                             resetn_i,
  input  logic                             flushPipeline_i,
  input  logic                             enable_i,
  output logic                             ready_o,
  input  logic [0:cachelineSizeInBits-1]   cacheline_i,
  input  logic [0:tagSize-1]               tag_i,
  input  logic [0:indexSize-1]             index_i,
  input  logic [0:offsetSize-1]            offset_i,
  output logic                             enable_o,
  input  logic                             ready_i,
  output logic [0:fetchWidth*instrWidth-1] fetchedPayload_o,
  output logic [0:fetchWidth-1]            slotValid_o,
  output logic [0:tagSize-1]               tag_o,
  output logic [0:indexSize-1]             index_o,
  output logic [0:offsetSize-1]            offset_o,
  output logic                             lastBeat_o
);

  localparam int wordsPerLineC = wordsPerLine(offsetSize);
  localparam int wIdxWidth     = wordIdxBits(offsetSize) + 1;
  localparam int sumWidth      = wIdxWidth + 1;

  fetchState_e                      state_q, state_d;
  logic [0:cachelineSizeInBits-1]   lineBuf_q, lineBuf_d;
  logic [0:tagSize-1]               tag_q, tag_d;
  logic [0:indexSize-1]             index_q, index_d;
  logic [wIdxWidth-1:0]             wIdx_q, wIdx_d;

  logic                             emitting;
  logic                             lastBeat;
  logic                             handshake;
  logic                             acceptLine;
  logic [0:fetchWidth*instrWidth-1] groupPayload;
  logic [0:fetchWidth-1]            groupValid;
  logic                             unusedOffsetLow;

  // The two byte-select bits of the offset are dropped: fetch is word aligned.
  assign unusedOffsetLow = ^offset_i[offsetSize-2:offsetSize-1];

  assign emitting   = (state_q == EMIT);
  assign lastBeat   = (sumWidth'(wIdx_q) + sumWidth'(fetchWidth)) >= sumWidth'(wordsPerLineC);
  assign handshake  = emitting & ready_i;

  // A new line may enter while idle, or in the very cycle the last beat of
  // the current line is consumed, which keeps back-to-back lines bubble free.
  assign ready_o    = ~flushPipeline_i & (~emitting | (lastBeat & ready_i));
  assign acceptLine = ready_o & enable_i;

  always_comb begin
    state_d   = state_q;
    lineBuf_d = lineBuf_q;
    tag_d     = tag_q;
    index_d   = index_q;
    wIdx_d    = wIdx_q;

    if (flushPipeline_i) begin
      state_d = IDLE;
    end else if (acceptLine) begin
      state_d   = EMIT;
      lineBuf_d = cacheline_i;
      tag_d     = tag_i;
      index_d   = index_i;
      wIdx_d    = wIdxWidth'(offset_i[0:offsetSize-3]);
    end else if (handshake) begin
      if (lastBeat) begin
        state_d = IDLE;
      end else begin
        wIdx_d = wIdx_q + wIdxWidth'(fetchWidth);
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      tag_q   <= '0;
      index_q <= '0;
      wIdx_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      wIdx_q  <= wIdx_d;
    end
  end

  // The line buffer carries no reset; its contents only reach the outputs
  // while a line is being emitted.
  always_ff @(posedge clock_i) begin
    lineBuf_q <= lineBuf_d;
  end

  fetch_group_select #(
    .cachelineSizeInBits(cachelineSizeInBits),
    .instrWidth         (instrWidth),
    .fetchWidth         (fetchWidth),
    .wIdxWidth          (wIdxWidth)
  ) uGroupSelect (
    .line_i     (lineBuf_q),
    .wIdx_i     (wIdx_q),
    .payload_o  (groupPayload),
    .slotValid_o(groupValid)
  );

  assign enable_o         = emitting;
  assign fetchedPayload_o = emitting ? groupPayload : '0;
  assign slotValid_o      = emitting ? groupValid : '0;
  assign lastBeat_o       = emitting & lastBeat;
  assign tag_o            = tag_q;
  assign index_o          = index_q;
  assign offset_o         = offsetSize'({wIdx_q, 2'b00});

endmodule
